// File: rtl/vt_pkg.sv
// rtl/vt_pkg.sv - shared constants, state encoding and helpers for vec_tester
package vt_pkg;

    // FSM state encoding
    typedef logic [3:0] vt_state_t;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_LD_CNT = 4'd1;
    localparam logic [3:0] ST_LD_DRV = 4'd2;
    localparam logic [3:0] ST_LD_EXP = 4'd3;
    localparam logic [3:0] ST_FETCH  = 4'd4;
    localparam logic [3:0] ST_DRIVE  = 4'd5;
    localparam logic [3:0] ST_SETTLE = 4'd6;
    localparam logic [3:0] ST_CHECK  = 4'd7;
    localparam logic [3:0] ST_TX     = 4'd8;

    // Command bytes accepted in IDLE
    localparam logic [7:0] CMD_LOAD = 8'h01;
    localparam logic [7:0] CMD_RUN  = 8'h02;

    // Report header and single-byte error replies
    localparam logic [7:0] RPT_HDR   = 8'hA5;
    localparam logic [7:0] ERR_CNT   = 8'hE1;
    localparam logic [7:0] ERR_TMO   = 8'hE2;
    localparam logic [7:0] ERR_EMPTY = 8'hE3;
    localparam logic [7:0] ERR_CMD   = 8'hEE;

    // Saturating 8-bit increment for the fail counter
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/vt_pattern_mem.sv
// rtl/vt_pattern_mem.sv - DEPTH x 2*WIDTH pattern RAM, one write port, one registered read port
//
// Ports:
//   clk    - clock
//   we     - write enable, writes wdata to waddr
//   waddr  - write address
//   wdata  - {drive, expect} pair
//   re     - read enable, rdata updates on the next edge
//   raddr  - read address
//   rdata  - registered {drive, expect} pair, holds while re is low
module vt_pattern_mem #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [2*WIDTH-1:0] wdata,
    input  logic               re,
    input  logic [AW-1:0]      raddr,
    output logic [2*WIDTH-1:0] rdata
);

    logic [2*WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/vec_tester.sv
// rtl/vec_tester.sv - UART-loaded drive/expect vector tester with compare, fail count and report
//
// Optional feature macro: VT_TIMEOUT_EN (inter-byte load timeout of TIMEOUT cycles)
//
// Ports:
//   in_clk, in_rst            - clock, asynchronous active-low reset
//   in_rx_data, in_rx_valid   - received byte and its one-cycle strobe
//   out_tx_data, out_tx_valid - byte to transmit, held until in_tx_ready
//   in_tx_ready               - transmitter accept
//   in_start, in_abort        - one-cycle run / abort requests
//   out_drive, in_sense       - tester pin drive and sense vectors
//   out_busy                  - high whenever the FSM is not IDLE
//   out_status                - sticky OR of mismatch bits of the last run
module vec_tester
    import vt_pkg::*;
#(
    parameter int WIDTH   = 6,
    parameter int DEPTH   = 16,
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 1000000
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic [7:0]       in_rx_data,
    input  logic             in_rx_valid,
    output logic [7:0]       out_tx_data,
    output logic             out_tx_valid,
    input  logic             in_tx_ready,
    input  logic             in_start,
    input  logic             in_abort,
    output logic [WIDTH-1:0] out_drive,
    input  logic [WIDTH-1:0] in_sense,
    output logic             out_busy,
    output logic [WIDTH-1:0] out_status
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(SETTLE + 1);

    vt_state_t          state;
    logic [CW-1:0]      loaded;
    logic [CW-1:0]      ld_n;
    logic [CW-1:0]      idx;
    logic [WIDTH-1:0]   drv_hold;
    logic [SW-1:0]      settle_cnt;
    logic [7:0]         fail_cnt;
    logic [7:0]         ff_idx;
    logic [1:0]         tx_ptr;
    logic               tx_report;

    logic               run_req;
    logic               last_vec;
    logic               tmo_hit;
    logic               mem_we;
    logic               mem_re;
    logic [AW-1:0]      mem_waddr;
    logic [AW-1:0]      mem_raddr;
    logic [2*WIDTH-1:0] mem_wdata;
    logic [2*WIDTH-1:0] mem_rdata;
    logic [WIDTH-1:0]   exp_cur;
    logic [WIDTH-1:0]   drv_cur;
    logic [WIDTH-1:0]   diff;

    assign out_busy = (state != ST_IDLE);

    // in_start takes priority; a RUN byte in the same cycle is simply absorbed
    assign run_req  = in_start || (in_rx_valid && (in_rx_data == CMD_RUN));
    assign last_vec = (idx == loaded - CW'(1));

    // idx doubles as load write pointer and run vector pointer
    assign mem_we    = (state == ST_LD_EXP) && in_rx_valid && !in_abort && !tmo_hit;
    assign mem_waddr = AW'(idx);
    assign mem_wdata = {drv_hold, in_rx_data[WIDTH-1:0]};

    // Read is issued one cycle ahead of FETCH so the pair is already
    // on mem_rdata during FETCH and out_drive can change on DRIVE entry.
    // mem_rdata then holds through CHECK, which uses the expect half.
    assign mem_re    = ((state == ST_IDLE) && run_req && (loaded != '0)) ||
                       ((state == ST_CHECK) && !last_vec);
    assign mem_raddr = (state == ST_CHECK) ? AW'(idx + CW'(1)) : '0;

    assign drv_cur = mem_rdata[2*WIDTH-1:WIDTH];
    assign exp_cur = mem_rdata[WIDTH-1:0];
    assign diff    = in_sense ^ exp_cur;

    vt_pattern_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (in_clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (mem_re),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

`ifdef VT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_cnt;
    logic          in_load;

    assign in_load = (state == ST_LD_CNT) || (state == ST_LD_DRV) || (state == ST_LD_EXP);
    assign tmo_hit = in_load && !in_rx_valid && (tmo_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            tmo_cnt <= '0;
        end else if (!in_load || in_rx_valid) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end
`else
    logic unused_timeout;

    assign tmo_hit        = 1'b0;
    assign unused_timeout = (TIMEOUT > 0);
`endif

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state        <= ST_IDLE;
            loaded       <= '0;
            ld_n         <= '0;
            idx          <= '0;
            drv_hold     <= '0;
            settle_cnt   <= '0;
            fail_cnt     <= '0;
            ff_idx       <= 8'hFF;
            tx_ptr       <= '0;
            tx_report    <= 1'b0;
            out_drive    <= '0;
            out_tx_data  <= '0;
            out_tx_valid <= 1'b0;
            out_status   <= '0;
        end else if (in_abort && (state != ST_IDLE)) begin
            // loaded only changes on the final pair, so an abort never touches it
            state        <= ST_IDLE;
            out_drive    <= '0;
            out_tx_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (run_req) begin
                        if (loaded == '0) begin
                            out_tx_data  <= ERR_EMPTY;
                            out_tx_valid <= 1'b1;
                            tx_ptr       <= '0;
                            tx_report    <= 1'b0;
                            state        <= ST_TX;
                        end else begin
                            out_status <= '0;
                            fail_cnt   <= '0;
                            ff_idx     <= 8'hFF;
                            idx        <= '0;
                            state      <= ST_FETCH;
                        end
                    end else if (in_rx_valid) begin
                        if (in_rx_data == CMD_LOAD) begin
                            state <= ST_LD_CNT;
                        end else begin
                            out_tx_data  <= ERR_CMD;
                            out_tx_valid <= 1'b1;
                            tx_ptr       <= '0;
                            tx_report    <= 1'b0;
                            state        <= ST_TX;
                        end
                    end
                end

                ST_LD_CNT: begin
                    if (tmo_hit) begin
                        out_tx_data  <= ERR_TMO;
                        out_tx_valid <= 1'b1;
                        tx_ptr       <= '0;
                        tx_report    <= 1'b0;
                        state        <= ST_TX;
                    end else if (in_rx_valid) begin
                        if ((in_rx_data == 8'h00) || ({1'b0, in_rx_data} > 9'(DEPTH))) begin
                            out_tx_data  <= ERR_CNT;
                            out_tx_valid <= 1'b1;
                            tx_ptr       <= '0;
                            tx_report    <= 1'b0;
                            state        <= ST_TX;
                        end else begin
                            ld_n  <= CW'(in_rx_data);
                            idx   <= '0;
                            state <= ST_LD_DRV;
                        end
                    end
                end

                ST_LD_DRV: begin
                    if (tmo_hit) begin
                        out_tx_data  <= ERR_TMO;
                        out_tx_valid <= 1'b1;
                        tx_ptr       <= '0;
                        tx_report    <= 1'b0;
                        state        <= ST_TX;
                    end else if (in_rx_valid) begin
                        drv_hold <= in_rx_data[WIDTH-1:0];
                        state    <= ST_LD_EXP;
                    end
                end

                ST_LD_EXP: begin
                    if (tmo_hit) begin
                        out_tx_data  <= ERR_TMO;
                        out_tx_valid <= 1'b1;
                        tx_ptr       <= '0;
                        tx_report    <= 1'b0;
                        state        <= ST_TX;
                    end else if (in_rx_valid) begin
                        if (idx == ld_n - CW'(1)) begin
                            loaded <= ld_n;
                            state  <= ST_IDLE;
                        end else begin
                            idx   <= idx + CW'(1);
                            state <= ST_LD_DRV;
                        end
                    end
                end

                ST_FETCH: begin
                    out_drive <= drv_cur;
                    state     <= ST_DRIVE;
                end

                ST_DRIVE: begin
                    // SETTLE state lasts exactly SETTLE cycles
                    settle_cnt <= SW'(SETTLE - 1);
                    state      <= ST_SETTLE;
                end

                ST_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= ST_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - SW'(1);
                    end
                end

                ST_CHECK: begin
                    if (diff != '0) begin
                        fail_cnt   <= sat_inc8(fail_cnt);
                        out_status <= out_status | diff;
                        // fail_cnt saturates and never wraps, so zero means first failure
                        if (fail_cnt == 8'd0) begin
                            ff_idx <= 8'(idx);
                        end
                    end
                    if (last_vec) begin
                        out_tx_data  <= RPT_HDR;
                        out_tx_valid <= 1'b1;
                        tx_ptr       <= '0;
                        tx_report    <= 1'b1;
                        state        <= ST_TX;
                    end else begin
                        idx   <= idx + CW'(1);
                        state <= ST_FETCH;
                    end
                end

                ST_TX: begin
                    // Drive is released one cycle after the last check so the
                    // final vector is held for a full vector period.
                    out_drive <= '0;
                    if (in_tx_ready) begin
                        if (!tx_report || (tx_ptr == 2'd2)) begin
                            out_tx_valid <= 1'b0;
                            state        <= ST_IDLE;
                        end else begin
                            tx_ptr      <= tx_ptr + 2'd1;
                            out_tx_data <= (tx_ptr == 2'd0) ? fail_cnt : ff_idx;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vec_tester.sv
// tb/tb_vec_tester.sv - self-checking bench for vec_tester with a behavioural report model
`timescale 1ns/1ps
module tb_vec_tester;

    localparam int WIDTH   = 6;
    localparam int DEPTH   = 16;
    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 100;

    logic             in_clk = 1'b0;
    logic             in_rst = 1'b0;
    logic [7:0]       in_rx_data = 8'h00;
    logic             in_rx_valid = 1'b0;
    logic [7:0]       out_tx_data;
    logic             out_tx_valid;
    logic             in_tx_ready = 1'b0;
    logic             in_start = 1'b0;
    logic             in_abort = 1'b0;
    logic [WIDTH-1:0] out_drive;
    logic [WIDTH-1:0] in_sense;
    logic             out_busy;
    logic [WIDTH-1:0] out_status;

    logic [5:0] sense_and = 6'h3F;
    logic [5:0] sense_xor = 6'h00;

    int checks = 0;
    int errors = 0;

    logic [7:0] tx_q[$];
    logic [7:0] v_drv[DEPTH];
    logic [7:0] v_exp[DEPTH];
    logic [5:0] m_drv[DEPTH];
    logic [5:0] m_exp[DEPTH];
    int         m_cnt = 0;
    int         rdy_cyc = 0;
    logic       hold_pend = 1'b0;
    logic [7:0] hold_data = 8'h00;

    always #5 in_clk = ~in_clk;

    // Pin loopback with optional stuck/inverted bits
    assign in_sense = (out_drive & sense_and) ^ sense_xor;

    vec_tester #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .SETTLE  (SETTLE),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .in_clk       (in_clk),
        .in_rst       (in_rst),
        .in_rx_data   (in_rx_data),
        .in_rx_valid  (in_rx_valid),
        .out_tx_data  (out_tx_data),
        .out_tx_valid (out_tx_valid),
        .in_tx_ready  (in_tx_ready),
        .in_start     (in_start),
        .in_abort     (in_abort),
        .out_drive    (out_drive),
        .in_sense     (in_sense),
        .out_busy     (out_busy),
        .out_status   (out_status)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Transmitter accepts one cycle in three
    initial begin
        forever begin
            @(posedge in_clk);
            #1;
            rdy_cyc++;
            in_tx_ready = (rdy_cyc % 3 == 0);
        end
    end

    // Byte collector and hold-stability monitor
    initial begin
        forever begin
            @(negedge in_clk);
            if (hold_pend && out_tx_valid) check("tx_stable", out_tx_data, hold_data);
            if (out_tx_valid && in_tx_ready) tx_q.push_back(out_tx_data);
            hold_pend = out_tx_valid && !in_tx_ready;
            hold_data = out_tx_data;
        end
    end

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_rx_data  = b;
        in_rx_valid = 1'b1;
        tick();
        in_rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
    endtask

    task automatic pulse_abort();
        in_abort = 1'b1;
        tick();
        in_abort = 1'b0;
    endtask

    function automatic logic [31:0] pop_byte();
        if (tx_q.size() == 0) return 32'hFFFF_FFFF;
        return {24'h0, tx_q.pop_front()};
    endfunction

    task automatic wait_bytes(input int n, input int budget, input string tag);
        int t;
        t = 0;
        while (tx_q.size() < n && t < budget) begin
            @(negedge in_clk);
            t++;
        end
        check(tag, tx_q.size(), n);
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while (out_busy && t < 100) begin
            @(negedge in_clk);
            t++;
        end
        check(tag, out_busy, 1'b0);
    endtask

    // Sends a LOAD of count n but only npairs pairs; the model count moves only on completion
    task automatic send_load(input int n, input int npairs);
        send_byte(8'h01);
        send_byte(8'(n));
        for (int i = 0; i < npairs; i++) begin
            send_byte(v_drv[i]);
            send_byte(v_exp[i]);
            m_drv[i] = v_drv[i][5:0];
            m_exp[i] = v_exp[i][5:0];
        end
        if (npairs == n) m_cnt = n;
    endtask

    task automatic model_report(output logic [7:0] e_fail, output logic [7:0] e_first,
                                output logic [5:0] e_stat);
        logic [5:0] d;
        e_fail  = 8'd0;
        e_first = 8'hFF;
        e_stat  = 6'd0;
        for (int i = 0; i < m_cnt; i++) begin
            d = ((m_drv[i] & sense_and) ^ sense_xor) ^ m_exp[i];
            if (d != 6'd0) begin
                if (e_fail == 8'd0) e_first = 8'(i);
                if (e_fail != 8'd255) e_fail = e_fail + 8'd1;
                e_stat = e_stat | d;
            end
        end
    endtask

    task automatic check_report(input string tag);
        logic [7:0] ef;
        logic [7:0] efi;
        logic [5:0] es;
        model_report(ef, efi, es);
        wait_bytes(3, DEPTH * (SETTLE + 3) + 100, {tag, "_len"});
        check({tag, "_hdr"}, pop_byte(), 32'hA5);
        check({tag, "_fails"}, pop_byte(), {24'h0, ef});
        check({tag, "_first"}, pop_byte(), {24'h0, efi});
        wait_idle({tag, "_idle"});
        check({tag, "_status"}, out_status, es);
        repeat (6) tick();
        check({tag, "_extra"}, tx_q.size(), 0);
    endtask

    // Launch a run, poke in_start while busy (must be ignored), then compare the report
    task automatic run_check(input string tag, input bit use_cmd);
        tx_q.delete();
        if (use_cmd) send_byte(8'h02);
        else pulse_start();
        repeat (3) tick();
        pulse_start();
        check_report(tag);
    endtask

    task automatic cmd_reply(input string tag, input logic [7:0] cmd, input logic [7:0] code);
        tx_q.delete();
        send_byte(cmd);
        wait_bytes(1, 50, {tag, "_len"});
        check(tag, pop_byte(), {24'h0, code});
        wait_idle({tag, "_idle"});
    endtask

    initial begin
        int n15;
        int n2a;
        int t;
        int n;

        // Reset values
        repeat (3) @(negedge in_clk);
        check("rst_drive", out_drive, 0);
        check("rst_tx_valid", out_tx_valid, 0);
        check("rst_tx_data", out_tx_data, 0);
        check("rst_busy", out_busy, 0);
        check("rst_status", out_status, 0);
        @(posedge in_clk);
        #1 in_rst = 1'b1;
        tick();

        // Bad counts, then RUN with nothing loaded
        send_byte(8'h01);
        cmd_reply("bad_cnt_17", 8'h11, 8'hE1);
        send_byte(8'h01);
        cmd_reply("bad_cnt_0", 8'h00, 8'hE1);
        cmd_reply("run_empty", 8'h02, 8'hE3);
        cmd_reply("unknown_cmd", 8'h7F, 8'hEE);

        // Loopback run of two vectors
        v_drv[0] = 8'h15; v_exp[0] = 8'h15;
        v_drv[1] = 8'h2A; v_exp[1] = 8'h2A;
        send_load(2, 2);
        check("idle_after_load", out_busy, 0);
        tx_q.delete();
        pulse_start();
        check("busy_after_start", out_busy, 1);
        n15 = 0;
        n2a = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge in_clk);
            if (out_drive == 6'h15) n15++;
            else if (out_drive == 6'h2A) n2a++;
        end
        check("hold_vec0", n15, SETTLE + 3);
        check("hold_vec1", n2a, SETTLE + 3);
        check_report("loopback");

        // Sense bit 0 stuck low
        sense_and = 6'h3E;
        run_check("stuck_bit0", 1'b0);
        sense_and = 6'h3F;

        // Abort during SETTLE of vector 1, then rerun with RUN command
        tx_q.delete();
        pulse_start();
        t = 0;
        while (out_drive != 6'h2A && t < 40) begin
            @(negedge in_clk);
            t++;
        end
        check("reach_vec1", out_drive, 6'h2A);
        tick();
        pulse_abort();
        check("abort_drive", out_drive, 0);
        check("abort_busy", out_busy, 0);
        check("abort_tx_valid", out_tx_valid, 0);
        repeat (20) tick();
        check("abort_no_reply", tx_q.size(), 0);
        run_check("rerun", 1'b1);

        // in_start and an unknown byte together: start wins, byte dropped
        tx_q.delete();
        in_start    = 1'b1;
        in_rx_data  = 8'h7F;
        in_rx_valid = 1'b1;
        tick();
        in_start    = 1'b0;
        in_rx_valid = 1'b0;
        check_report("start_vs_rx");

        // Aborted LOAD: pair 0 rewritten, count stays 2
        v_drv[0] = 8'h3F; v_exp[0] = 8'h00;
        send_load(3, 1);
        send_byte(8'h11);
        check("busy_in_load", out_busy, 1);
        pulse_abort();
        check("load_abort_idle", out_busy, 0);
        run_check("after_load_abort", 1'b1);

        // Randomised loads and pin faults
        for (int it = 0; it < 8; it++) begin
            n = (it == 0) ? DEPTH : int'($urandom_range(1, DEPTH));
            for (int i = 0; i < n; i++) begin
                v_drv[i] = 8'($urandom);
                v_exp[i] = ($urandom_range(0, 1) == 1) ? v_drv[i] ^ 8'hC0 : 8'($urandom);
            end
            send_load(n, n);
            sense_and = ($urandom_range(0, 1) == 1) ? 6'h3F : 6'($urandom);
            sense_xor = ($urandom_range(0, 2) == 0) ? 6'h00 : 6'($urandom);
            run_check($sformatf("rand%0d", it), it[0]);
        end
        sense_and = 6'h3F;
        sense_xor = 6'h00;

        // Load stalls after the first drive byte
        tx_q.delete();
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h15);
`ifdef VT_TIMEOUT_EN
        t = 0;
        while (tx_q.size() < 1 && t < 300) begin
            @(negedge in_clk);
            t++;
        end
        check("tmo_len", tx_q.size(), 1);
        check("tmo_code", pop_byte(), 32'hE2);
        check("tmo_latency", (t >= TIMEOUT && t <= TIMEOUT + 4), 1);
        wait_idle("tmo_idle");
`else
        repeat (10000) tick();
        check("no_tmo_busy", out_busy, 1);
        check("no_tmo_reply", tx_q.size(), 0);
        pulse_abort();
        check("no_tmo_abort", out_busy, 0);
`endif
        run_check("after_stall", 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vec_tester.md
# vec_tester

Parametrised vector tester engine: loads drive/expect vector pairs from the UART receive byte stream into an internal pattern memory, and applies them to WIDTH tester pins. It samples the pins back after a settle time, compares and accumulates mismatches. It returns a 3-byte report over the UART transmit path. It sits between the UART rx/tx, key driver and LED driver, and replaces the fixed 6-bit fsm/mem pair with a WIDTH × DEPTH generalisation that adds compare, fail counting and a run command.

## Interface
- WIDTH, 6, number of tester channels, 1..8.
- DEPTH, 16, vector memory depth, 2..256.
- SETTLE, 4, cycles between drive update and sample, ≥1.
- TIMEOUT, 1000000, inter-byte load timeout in cycles (used only with VT_TIMEOUT_EN).
- in_clk  in  1  system clock.
- in_rst  in  1  reset, asynchronous, active-low.
- in_rx_data  in  8  received byte.
- in_rx_valid  in  1  one-cycle strobe, in_rx_data valid.
- out_tx_data  out  8  byte to transmit.
- out_tx_valid  out  1  byte pending; held until accepted.
- in_tx_ready  in  1  transmitter accepts out_tx_data when high with out_tx_valid.
- in_start  in  1  one-cycle run request (debounced key).
- in_abort  in  1  one-cycle abort request (debounced key).
- out_drive  out  WIDTH  pin drive vector.
- in_sense  in  WIDTH  pin sense vector, synchronous to in_clk.
- out_busy  out  1  high in any state other than IDLE.
- out_status  out  WIDTH  sticky OR of mismatch bits of the last run (LED display).

## Operation
- Reset values: out_drive 0, out_tx_data 0, out_tx_valid 0, out_busy 0, out_status 0, loaded count 0, state IDLE. Memory contents are undefined.
- Commands are accepted in IDLE only:
  - 0x01 LOAD: the next byte is count n. n = 0 or n > DEPTH → reply 0xE1. Otherwise n pairs (drive, expect) follow and are written to addresses 0..n-1. Bits above WIDTH are ignored. loaded count = n only after the last pair is written.
  - 0x02 RUN: same effect as in_start.
  - Any other byte → reply 0xEE.
- States:
  - IDLE
  - LD_CNT, LD_DRV, LD_EXP (load sequence)
  - FETCH, DRIVE, SETTLE, CHECK (run sequence)
  - TX (report/reply)
- Run:
  - loaded count 0 → reply 0xE3.
  - Otherwise clear out_status and fail count, then step i = 0..n-1 through FETCH → DRIVE (out_drive ← drive[i], settle counter ← SETTLE) → SETTLE (count down to 0) → CHECK.
  - In CHECK: diff = in_sense ^ expect[i]. If diff ≠ 0: fail count increments, saturating at 255; out_status |= diff; first-fail index latched if this is the first failure.
  - After the last CHECK: out_drive ← 0, then report 0xA5, fail count, first-fail index (0xFF if none).
- TX: bytes are sent in order, one per accepted handshake. Return to IDLE after the last byte is accepted.
- Boundary rules:
  - in_rx_valid outside IDLE/LD_* is ignored.
  - in_start and in_rx_valid in the same IDLE cycle: start wins and the byte is dropped.
  - in_abort in any non-IDLE state: next cycle state IDLE, out_drive 0, out_tx_valid 0, no reply. Loaded count is unchanged, except that an aborted LOAD leaves it unchanged from before that LOAD started.
  - in_start while busy is ignored.

## Timing
- Memory read latency is 1 cycle (FETCH).
- out_drive changes on the cycle DRIVE is entered.
- in_sense is sampled in CHECK, exactly SETTLE+1 cycles after the out_drive change.
- Vector period is SETTLE+3 cycles.
- The first report byte is valid the cycle after the last CHECK.
- out_tx_data stays stable while out_tx_valid && !in_tx_ready.
- out_busy rises the cycle after the start/command is accepted.

## Configuration
- VT_TIMEOUT_EN defined: in LD_CNT/LD_DRV/LD_EXP, a counter resets on every in_rx_valid. When it reaches TIMEOUT, the load is aborted, reply 0xE2 is sent and the block returns to IDLE; loaded count is unchanged.
- Undefined: load states wait indefinitely and no counter is synthesised.

## Structure
- Package vt_pkg holds:
  - state enum
  - command constants CMD_LOAD 0x01, CMD_RUN 0x02
  - reply constants RPT_HDR 0xA5, ERR_CNT 0xE1, ERR_TMO 0xE2, ERR_EMPTY 0xE3, ERR_CMD 0xEE
- Sub-module vt_pattern_mem: DEPTH × 2·WIDTH synchronous RAM with one write port and one read port, 1-cycle read.

## Test plan
- WIDTH 6, SETTLE 4, loopback (in_sense = out_drive), in_tx_ready toggling 1-of-3.
  - Stimulus: load 01 02 15 15 2A 2A, then in_start.
  - Response: out_drive 0x15 then 0x2A, each held 7 cycles; report A5 00 FF with no byte lost; out_status 0.
- Same load, in_sense bit0 forced 0.
  - Response: report A5 01 00, out_status 0x01.
- Bad load count.
  - Stimulus: 01 11.
  - Response: reply E1, out_busy low after TX; then 02 → reply E3 (nothing loaded).
- Unknown command.
  - Stimulus: byte 0x7F in IDLE.
  - Response: reply EE.
- Abort mid-run.
  - Stimulus: in_abort during SETTLE of vector 1.
  - Response: next cycle out_drive 0, out_busy 0, no out_tx_valid.
  - Follow-up: a subsequent 02 reruns both vectors.
- Load timeout.
  - Stimulus: 01 02 15, then silence.
  - With VT_TIMEOUT_EN (TIMEOUT 100): reply E2 after 100 cycles.
  - Without VT_TIMEOUT_EN: still in LD_EXP after 10 000 cycles.
